// File: rtl/memory_read_sequencer.sv
// Multi-bank cell-memory read sequencer: fetches one word per bank channel from a
// synchronous RAM, tracks read latency with a tag pipeline and publishes all channels at once.
module memory_read_sequencer #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 13,
  parameter int NUM_CH      = 2,
  parameter int ROW_BITS    = 5,
  parameter int COL_BITS    = 7,
  parameter int BANK_STRIDE = 4096,
  parameter int RD_LAT      = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  input  logic                     flush_in,
  input  logic [ROW_BITS-1:0]      row_in,
  input  logic [COL_BITS-1:0]      col_in,
  output logic [ADDR_W-1:0]        read_addr,
  output logic                     rd_en,
  input  logic [DATA_W-1:0]        mem_data_in,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     valid_out,
  output logic                     busy_out,
  output logic [1:0]               state_dbg
);

  // Handshake: start_in is accepted only in IDLE/DONE without flush_in; each accepted
  // request yields exactly one valid_out pulse unless flushed or reset; no backpressure.

  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int AW4   = ADDR_W + 4;
  localparam logic [CNT_W-1:0] NUM_CH_C  = CNT_W'(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_CH_C = CNT_W'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("NUM_CH must be 1..8");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("RD_LAT must be 1..4");
  end
  if (NUM_CH * BANK_STRIDE > 2 ** ADDR_W) begin : g_bad_banks
    $error("NUM_CH*BANK_STRIDE exceeds the address space");
  end
  if (2 ** (ROW_BITS + COL_BITS) > BANK_STRIDE) begin : g_bad_stride
    $error("row/column space exceeds BANK_STRIDE");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                          state_q, state_d;
  logic [ROW_BITS-1:0]             row_q, row_d;
  logic [COL_BITS-1:0]             col_q, col_d;
  logic [CNT_W-1:0]                iss_q, iss_d;
  logic [ADDR_W-1:0]               read_addr_q, read_addr_d;
  logic                            rd_en_q, rd_en_d;
  logic [RD_LAT-1:0]               tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][CNT_W-1:0]    tag_ch_q, tag_ch_d;
  logic [NUM_CH*DATA_W-1:0]        stage_q, stage_d;
  logic [NUM_CH*DATA_W-1:0]        data_out_q, data_out_d;
  logic                            valid_q, valid_d;
  logic                            busy_q, busy_d;

  logic             accept, busy_st, cap_vld, last_cap;
  logic [CNT_W-1:0] cap_ch;

  function automatic logic [ADDR_W-1:0] calc_addr(input logic [CNT_W-1:0]    ch,
                                                  input logic [ROW_BITS-1:0] row,
                                                  input logic [COL_BITS-1:0] col);
    return ADDR_W'(AW4'(ch) * AW4'(BANK_STRIDE) + (AW4'(row) << COL_BITS) + AW4'(col));
  endfunction

  assign busy_st  = (state_q == ISSUE) || (state_q == DRAIN);
  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start_in && !flush_in;
  // The oldest tag stage marks the cycle whose RAM data must be captured at this edge.
  assign cap_vld  = tag_vld_q[RD_LAT-1];
  assign cap_ch   = tag_ch_q[RD_LAT-1];
  assign last_cap = cap_vld && (cap_ch == LAST_CH_C);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      iss_q       <= '0;
      read_addr_q <= '0;
      rd_en_q     <= 1'b0;
      tag_vld_q   <= '0;
      tag_ch_q    <= '0;
      stage_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      iss_q       <= iss_d;
      read_addr_q <= read_addr_d;
      rd_en_q     <= rd_en_d;
      tag_vld_q   <= tag_vld_d;
      tag_ch_q    <= tag_ch_d;
      stage_q     <= stage_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        if (flush_in)               state_d = IDLE;
        else if (last_cap)          state_d = DONE;
        else if (iss_q == NUM_CH_C) state_d = DRAIN;
      end
      DRAIN: begin
        if (flush_in)      state_d = IDLE;
        else if (last_cap) state_d = DONE;
      end
      DONE:    state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    iss_d       = iss_q;
    read_addr_d = '0;
    rd_en_d     = 1'b0;
    stage_d     = stage_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    tag_vld_d   = '0;
    tag_ch_d    = '0;
    tag_vld_d[0] = rd_en_q;
    tag_ch_d[0]  = iss_q - CNT_W'(1);
    for (int j = 1; j < RD_LAT; j++) begin
      tag_vld_d[j] = tag_vld_q[j-1];
      tag_ch_d[j]  = tag_ch_q[j-1];
    end

    if (accept) begin
      // Channel 0 goes out straight from the request inputs so it appears in cycle 1.
      row_d       = row_in;
      col_d       = col_in;
      read_addr_d = calc_addr('0, row_in, col_in);
      rd_en_d     = 1'b1;
      iss_d       = CNT_W'(1);
      busy_d      = 1'b1;
    end else if (busy_st) begin
      if (flush_in) begin
        iss_d     = '0;
        busy_d    = 1'b0;
        stage_d   = '0;
        tag_vld_d = '0;
        tag_ch_d  = '0;
      end else begin
        if (cap_vld) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (cap_ch == CNT_W'(k)) stage_d[k*DATA_W +: DATA_W] = mem_data_in;
          end
        end
        if (iss_q < NUM_CH_C) begin
          read_addr_d = calc_addr(iss_q, row_q, col_q);
          rd_en_d     = 1'b1;
          iss_d       = iss_q + CNT_W'(1);
        end
        if (last_cap) begin
          data_out_d = stage_d;
          valid_d    = 1'b1;
          busy_d     = 1'b0;
          iss_d      = '0;
        end
      end
    end else begin
      busy_d = 1'b0;
      iss_d  = '0;
    end
  end

  assign read_addr = read_addr_q;
  assign rd_en     = rd_en_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_memory_read_sequencer.sv
// Bench for memory_read_sequencer: default instance plus a 4-channel, 3-cycle-latency instance,
// each with a latency-accurate RAM model; a monitor scores valid_out against expected queues.
module tb_memory_read_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b, flush;
  logic [4:0]  row;
  logic [6:0]  col;

  logic [12:0] addr_a;
  logic        rd_en_a, valid_a, busy_a;
  logic [23:0] mem_a;
  logic [47:0] data_a;
  logic [1:0]  state_a;

  logic [13:0] addr_b;
  logic        rd_en_b, valid_b, busy_b;
  logic [23:0] mem_b;
  logic [95:0] data_b;
  logic [1:0]  state_b;

  logic [23:0] pipe_a;
  logic [23:0] pipe_b [3];

  int n_checks;
  int n_fail;
  logic [47:0] exp_a_q[$];
  logic [95:0] exp_b_q[$];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  memory_read_sequencer dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .flush_in(flush),
    .row_in(row), .col_in(col), .read_addr(addr_a), .rd_en(rd_en_a),
    .mem_data_in(mem_a), .data_out(data_a), .valid_out(valid_a),
    .busy_out(busy_a), .state_dbg(state_a)
  );

  memory_read_sequencer #(.ADDR_W(14), .NUM_CH(4), .RD_LAT(3)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .flush_in(flush),
    .row_in(row), .col_in(col), .read_addr(addr_b), .rd_en(rd_en_b),
    .mem_data_in(mem_b), .data_out(data_b), .valid_out(valid_b),
    .busy_out(busy_b), .state_dbg(state_b)
  );

  // RAM contents: two fixed words, everything else tagged with its own address
  function automatic logic [23:0] ram_word(input logic [13:0] a);
    if (a == 14'd389)  return 24'hAAAAAA;
    if (a == 14'd4485) return 24'h555555;
    return 24'hC00000 | {10'd0, a};
  endfunction

  always @(posedge clk) begin
    pipe_a    <= rd_en_a ? ram_word({1'b0, addr_a}) : 24'hEEEEEE;
    pipe_b[0] <= rd_en_b ? ram_word(addr_b) : 24'hEEEEEE;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_a = pipe_a;
  assign mem_b = pipe_b[2];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid_a: got valid with data %0h expected none", data_a);
      end else begin
        check("data_a", {48'd0, data_a}, {48'd0, exp_a_q.pop_front()});
      end
    end
    if (valid_b === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid_b: got valid with data %0h expected none", data_b);
      end else begin
        check("data_b", data_b, exp_b_q.pop_front());
      end
    end
  end

  initial begin
    logic [13:0] exp_addr_b [4];
    exp_addr_b = '{14'd389, 14'd4485, 14'd8581, 14'd12677};
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; flush = 1'b0; row = '0; col = '0;
    repeat (3) tick();
    check("rst_addr_a",  96'(addr_a),  96'd0);
    check("rst_rd_en_a", 96'(rd_en_a), 96'd0);
    check("rst_data_a",  96'(data_a),  96'd0);
    check("rst_valid_a", 96'(valid_a), 96'd0);
    check("rst_busy_a",  96'(busy_a),  96'd0);
    check("rst_state_a", 96'(state_a), 96'd0);
    check("rst_data_b",  data_b,       96'd0);
    rst_n = 1'b1;
    tick();

    // Basic request: row 3, col 5
    start_a = 1'b1; row = 5'd3; col = 7'd5;
    exp_a_q.push_back(48'h555555AAAAAA);
    tick();
    start_a = 1'b0;
    check("t1_c1_addr",  96'(addr_a),  96'd389);
    check("t1_c1_rd_en", 96'(rd_en_a), 96'd1);
    check("t1_c1_busy",  96'(busy_a),  96'd1);
    tick();
    check("t1_c2_addr",  96'(addr_a),  96'd4485);
    check("t1_c2_rd_en", 96'(rd_en_a), 96'd1);
    check("t1_c2_valid", 96'(valid_a), 96'd0);
    tick();
    check("t1_c3_addr",  96'(addr_a),  96'd0);
    check("t1_c3_rd_en", 96'(rd_en_a), 96'd0);
    check("t1_c3_busy",  96'(busy_a),  96'd1);
    check("t1_c3_valid", 96'(valid_a), 96'd0);
    tick();
    check("t1_c4_valid", 96'(valid_a), 96'd1);
    check("t1_c4_busy",  96'(busy_a),  96'd0);
    check("t1_c4_state", 96'(state_a), 96'd3);
    tick();
    check("t1_c5_valid", 96'(valid_a), 96'd0);
    check("t1_c5_hold",  96'(data_a),  96'h555555AAAAAA);

    // Address wrap at the top of each bank, then a back-to-back request
    start_a = 1'b1; row = 5'd31; col = 7'd127;
    exp_a_q.push_back(48'hC01FFFC00FFF);
    tick();
    start_a = 1'b0;
    check("wrap_addr0", 96'(addr_a), 96'd4095);
    tick();
    check("wrap_addr1", 96'(addr_a), 96'd8191);
    tick();
    tick();
    check("wrap_valid", 96'(valid_a), 96'd1);
    start_a = 1'b1; row = 5'd0; col = 7'd1;
    exp_a_q.push_back(48'hC01001C00001);
    tick();
    start_a = 1'b0;
    check("b2b_addr0", 96'(addr_a),  96'd1);
    check("b2b_rd_en", 96'(rd_en_a), 96'd1);
    check("b2b_busy",  96'(busy_a),  96'd1);
    tick();
    check("b2b_addr1", 96'(addr_a), 96'd4097);
    tick();
    tick();
    check("b2b_valid", 96'(valid_a), 96'd1);
    tick();

    // Flush in cycle 2
    start_a = 1'b1; row = 5'd2; col = 7'd0;
    tick();
    start_a = 1'b0;
    check("fl_c1_addr", 96'(addr_a), 96'd256);
    tick();
    check("fl_c2_addr", 96'(addr_a), 96'd4352);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_c3_rd_en", 96'(rd_en_a), 96'd0);
    check("fl_c3_addr",  96'(addr_a),  96'd0);
    check("fl_c3_busy",  96'(busy_a),  96'd0);
    check("fl_c3_data",  96'(data_a),  96'hC01001C00001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fl_idle_valid", 96'(valid_a), 96'd0);
      check("fl_idle_rd_en", 96'(rd_en_a), 96'd0);
    end

    // Flush together with start in IDLE: request refused
    start_a = 1'b1; flush = 1'b1; row = 5'd1; col = 7'd2;
    tick();
    flush = 1'b0;
    check("fs_busy",  96'(busy_a),  96'd0);
    check("fs_rd_en", 96'(rd_en_a), 96'd0);
    exp_a_q.push_back(48'hC01082C00082);
    tick();
    start_a = 1'b0;
    check("post_fl_addr0", 96'(addr_a), 96'd130);
    tick();
    check("post_fl_addr1", 96'(addr_a), 96'd4226);
    tick();
    tick();
    check("post_fl_valid", 96'(valid_a), 96'd1);
    tick();

    // Reset mid-request
    start_a = 1'b1; row = 5'd4; col = 7'd0;
    tick();
    start_a = 1'b0;
    check("rs_c1_addr", 96'(addr_a), 96'd512);
    tick();
    rst_n = 1'b0;
    #1;
    check("rs_addr",  96'(addr_a),  96'd0);
    check("rs_rd_en", 96'(rd_en_a), 96'd0);
    check("rs_busy",  96'(busy_a),  96'd0);
    check("rs_data",  96'(data_a),  96'd0);
    check("rs_valid", 96'(valid_a), 96'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rs_after_busy",  96'(busy_a),  96'd0);
      check("rs_after_rd_en", 96'(rd_en_a), 96'd0);
      check("rs_after_state", 96'(state_a), 96'd0);
    end

    // Four channels, three-cycle latency; a start in cycle 3 must be ignored
    start_b = 1'b1; row = 5'd3; col = 7'd5;
    exp_b_q.push_back(96'hC03185C02185555555AAAAAA);
    for (int c = 1; c <= 11; c++) begin
      tick();
      start_b = (c == 2);
      if (c == 2) row = 5'd7;
      if (c <= 4) check("b_addr", 96'(addr_b), 96'(exp_addr_b[c-1]));
      else        check("b_addr_idle", 96'(addr_b), 96'd0);
      check("b_rd_en", 96'(rd_en_b), (c <= 4) ? 96'd1 : 96'd0);
      check("b_busy",  96'(busy_b),  (c <= 7) ? 96'd1 : 96'd0);
      check("b_valid", 96'(valid_b), (c == 8) ? 96'd1 : 96'd0);
    end

    repeat (3) tick();
    check("queue_a_empty", 96'(exp_a_q.size()), 96'd0);
    check("queue_b_empty", 96'(exp_b_q.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
